sha256_block_fetch: RTL and testbench
=====================================

# sha256_block_fetch

Upstream feeder for the SHA-256 compression core. On `start`, it reads a message of `NUM_OF_WORDS` 32-bit words from word-addressed memory and applies standard SHA-256 padding (0x80 marker and 64-bit bit-length). It presents the padded message one 512-bit block at a time on a valid/ready interface. The compression core consumes each block and raises `blk_ready` when it can take the next one.

## Interface
- `NUM_OF_WORDS`, 40, message length in 32-bit words (≥1; bit length = 32·`NUM_OF_WORDS`, < 2^32)
- `clk` in 1: single clock; all state on rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: begin a message; sampled only in IDLE
- `input_addr` in 16: word address of message word 0; sampled with `start`
- `mem_addr` out 16: read address to synchronous memory
- `mem_read_data` in 32: read data, valid one cycle after `mem_addr`
- `blk_valid` out 1: `blk_data` holds a complete padded block
- `blk_ready` in 1: consumer accepts block when high with `blk_valid`
- `blk_data` out 512: block, word 0 in [511:480], word 15 in [31:0]
- `blk_last` out 1: current block is final block of message
- `busy` out 1: high in any state other than IDLE
- `done` out 1: one-cycle pulse after final block handshake

## Operation
- NB = floor((`NUM_OF_WORDS`+2)/16)+1 blocks. Global word index g = 16·b + j (b block, j 0..15).
- Word content rules:
  - g < N: `mem_read_data` from `input_addr`+g
  - g = N: 32'h80000000
  - b = NB-1, j = 14: 32'h0 (high length word)
  - b = NB-1, j = 15: 32·N
  - all others: 0
- States:
  - IDLE: `start` → FETCH, with b=0, c=0, `input_addr` latched.
  - FETCH: counter c runs 0..16.
    - For c<16, drive `mem_addr` = latched addr + g(c) when g(c) < N; otherwise hold the previous address.
    - For c≥1, capture word c-1 into the block buffer using the content rules for g(c-1).
    - At c=16 → VALID.
  - VALID: `blk_valid`=1. `blk_data` and `blk_last` are stable until handshake.
    - On `blk_valid`&&`blk_ready`: if `blk_last` → DONE; else b+1, c=0 → FETCH.
  - DONE: `done`=1 for one cycle → IDLE.
- `start` in any state except IDLE is ignored. `input_addr` changes after the `start` cycle have no effect.
- `blk_ready` is ignored when `blk_valid`=0.
- Address arithmetic is 16-bit modulo, so it wraps past 16'hFFFF.

## Timing
- Reset values: `mem_addr`=0, `blk_valid`=0, `blk_data`=0, `blk_last`=0, `busy`=0, `done`=0, state IDLE, b=c=0.
- Reset mid-operation abandons the message immediately. No `done` is produced, and the next `start` begins from block 0.
- Latency: `blk_valid` rises 17 edges after the edge that samples `start`.
- After a non-final handshake, the next `blk_valid` rises 17 edges later. Throughput is one block per 18 cycles with `blk_ready` held high.
- `done` rises the edge after the final handshake and lasts one cycle. `busy` falls together with `done`.
- `start` asserted in the `done` cycle is ignored. It is accepted on the following cycle, in IDLE.
- Memory contract: the read port is synchronous with exactly one-cycle latency.

## Structure
- Shared `sha256_pkg` holds:
  - state enum {IDLE, FETCH, VALID, DONE}
  - `PAD_WORD` = 32'h80000000
  - function `num_blocks(n)` implementing the NB formula
  - `BLOCK_WORDS` = 16
- Single module; no sub-module. The padding mux and capture counter are small enough to inline.

## Test plan
- N=40, `input_addr`=16'h0100, memory word i = i+1:
  - 3 blocks, block0 words 1..16, block1 words 17..32
  - block2: w0..w7 = 33..40, w8 = 32'h80000000, w9..w14 = 0, w15 = 32'h00000500
  - `blk_last` only on block2; `done` pulse once
- N=13: 1 block; w13 = 32'h80000000, w14 = 0, w15 = 32'h000001A0; `blk_last`=1.
- N=14 and N=16 boundary cases:
  - N=14: 2 blocks; block0 w14 = 32'h80000000, w15 = 0; block1 all zero except w15 = 32'h000001C0.
  - N=16: block1 w0 = 32'h80000000, w15 = 32'h00000200.
- Backpressure: hold `blk_ready` low for 5 cycles in VALID. `blk_valid` and `blk_data` stay stable; handshake occurs on the first high cycle. Check 17-cycle start→valid latency.
- Reset and `start` handling:
  - Assert `rst` at c=7 of block1: all outputs zero next cycle, no `done`. A new `start` yields a correct block0.
  - Pulse `start` during FETCH/VALID: no effect on data or block count.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared definitions for the SHA-256 message feeder.
//   state_t      - block fetch FSM states
//   PAD_WORD     - word that carries the 0x80 padding marker
//   BLOCK_WORDS  - 32-bit words per 512-bit block
//   num_blocks() - padded block count for a message of n words
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] PAD_WORD    = 32'h8000_0000;
    localparam int          BLOCK_WORDS = 16;

    // One marker word plus two length words must fit after the message.
    function automatic int num_blocks(input int n);
        return (n + 2) / BLOCK_WORDS + 1;
    endfunction

endpackage

// File: rtl/sha256_block_fetch.sv
// sha256_block_fetch: reads an NUM_OF_WORDS-word message from a synchronous
// word-addressed memory, applies SHA-256 padding and hands it to the
// compression core one 512-bit block at a time.
//
// Ports
//   clk, rst        - clock, asynchronous active-high reset
//   start           - begin a message (only honoured in IDLE)
//   input_addr      - word address of message word 0, sampled with start
//   mem_addr        - memory read address (registered)
//   mem_read_data   - memory data, one cycle after mem_addr
//   blk_valid/ready - block handshake
//   blk_data        - padded block, word 0 in [511:480]
//   blk_last        - block on blk_data is the final one
//   busy            - FSM not in IDLE
//   done            - one-cycle pulse after the final handshake
//
// state | meaning
// IDLE  | waiting for start
// FETCH | cnt 0..16: issue reads for cnt<16, capture word cnt-1 for cnt>=1
// VALID | block presented, waiting for blk_ready
// DONE  | single-cycle done pulse
module sha256_block_fetch
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [15:0]  input_addr,
    output logic [15:0]  mem_addr,
    input  logic [31:0]  mem_read_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last,
    output logic         busy,
    output logic         done
);

    localparam int          NB      = num_blocks(NUM_OF_WORDS);
    localparam logic [31:0] N_W     = 32'(NUM_OF_WORDS);
    localparam logic [31:0] LAST_B  = 32'(NB - 1);
    localparam logic [31:0] BIT_LEN = 32'(32 * NUM_OF_WORDS);

    state_t      state, state_nxt;
    logic [31:0] blk_idx, blk_idx_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic [15:0] base_addr, base_nxt;

    logic [31:0] g_fetch;
    logic        fetch_en;
    logic [3:0]  cap_j;
    logic [31:0] g_cap;
    logic        cap_en;
    logic [31:0] cap_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        blk_idx_nxt = blk_idx;
        cnt_nxt     = cnt;
        base_nxt    = base_addr;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = FETCH;
                    blk_idx_nxt = 32'd0;
                    cnt_nxt     = 5'd0;
                    base_nxt    = input_addr;
                end
            end
            FETCH: begin
                if (cnt == 5'd16) begin
                    state_nxt = VALID;
                end else begin
                    cnt_nxt = cnt + 5'd1;
                end
            end
            VALID: begin
                if (blk_ready) begin
                    if (blk_idx == LAST_B) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt   = FETCH;
                        blk_idx_nxt = blk_idx + 32'd1;
                        cnt_nxt     = 5'd0;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // mem_addr is registered, so it is loaded with the address belonging to
    // the counter value being entered; data then arrives one cycle later.
    assign g_fetch  = {blk_idx_nxt[27:0], 4'b0000} + {27'd0, cnt_nxt};
    assign fetch_en = (state_nxt == FETCH) && (cnt_nxt < 5'd16) && (g_fetch < N_W);

    // Word captured at this edge was addressed two counter steps earlier.
    assign cap_j  = 4'(cnt - 5'd1);
    assign g_cap  = {blk_idx[27:0], 4'b0000} + {28'd0, cap_j};
    assign cap_en = (state == FETCH) && (cnt != 5'd0);

    always_comb begin
        cap_word = 32'd0;
        if (g_cap < N_W) begin
            cap_word = mem_read_data;
        end else if (g_cap == N_W) begin
            cap_word = PAD_WORD;
        end else if ((blk_idx == LAST_B) && (cap_j == 4'd15)) begin
            cap_word = BIT_LEN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_idx   <= 32'd0;
            cnt       <= 5'd0;
            base_addr <= 16'd0;
            mem_addr  <= 16'd0;
            blk_data  <= '0;
        end else begin
            blk_idx   <= blk_idx_nxt;
            cnt       <= cnt_nxt;
            base_addr <= base_nxt;
            if (fetch_en) begin
                mem_addr <= base_nxt + g_fetch[15:0];
            end
            // ~cap_j selects word slot 15-j, putting word 0 at the top.
            if (cap_en) begin
                blk_data[{~cap_j, 5'b00000} +: 32] <= cap_word;
            end
        end
    end

    assign blk_valid = (state == VALID);
    assign blk_last  = (state == VALID) && (blk_idx == LAST_B);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_sha256_block_fetch.sv
// Bench for sha256_block_fetch: four instances (N = 40, 13, 14, 16) share
// clock and reset. Stimulus pushes hand-written expected blocks into
// per-instance queues; a negedge monitor compares every presented block.
module tb_sha256_block_fetch;

    localparam int NI = 4;

    function automatic int nw(input int k);
        case (k)
            0:       return 40;
            1:       return 13;
            2:       return 14;
            default: return 16;
        endcase
    endfunction

    // Memory image: word at base 0x0100 + i holds i + 1.
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        logic [15:0] off;
        off = a - 16'h0100;
        return {16'd0, off} + 32'd1;
    endfunction

    // Block of 16 consecutive message words first..first+15.
    function automatic logic [511:0] seq_block(input int first);
        logic [511:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            r[511 - 32*j -: 32] = 32'(first + j);
        end
        return r;
    endfunction

    typedef struct packed {
        logic         last;
        logic [511:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start         [NI];
    logic [15:0]  input_addr    [NI];
    logic [15:0]  mem_addr      [NI];
    logic [31:0]  mem_read_data [NI];
    logic         blk_valid     [NI];
    logic         blk_ready     [NI];
    logic [511:0] blk_data      [NI];
    logic         blk_last      [NI];
    logic         busy          [NI];
    logic         done          [NI];

    exp_t exp_q [NI][$];
    int   done_cnt [NI];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    for (genvar gk = 0; gk < NI; gk++) begin : g_dut
        sha256_block_fetch #(.NUM_OF_WORDS(nw(gk))) u_dut (
            .clk           (clk),
            .rst           (rst),
            .start         (start[gk]),
            .input_addr    (input_addr[gk]),
            .mem_addr      (mem_addr[gk]),
            .mem_read_data (mem_read_data[gk]),
            .blk_valid     (blk_valid[gk]),
            .blk_ready     (blk_ready[gk]),
            .blk_data      (blk_data[gk]),
            .blk_last      (blk_last[gk]),
            .busy          (busy[gk]),
            .done          (done[gk])
        );
    end

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            mem_read_data[k] <= mem_word(mem_addr[k]);
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic push(input int k, input logic last, input logic [511:0] data);
        exp_t e;
        e.last = last;
        e.data = data;
        exp_q[k].push_back(e);
    endtask

    // Monitor: every cycle a block is presented it must match the queue head
    // (so stalls also prove stability); the head is retired on handshake.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            if (!rst && blk_valid[k]) begin
                if (exp_q[k].size() == 0) begin
                    chk($sformatf("unexpected_block_%0d", k), 512'd1, 512'd0);
                end else begin
                    e = exp_q[k][0];
                    chk($sformatf("blk_data_%0d", k), blk_data[k], e.data);
                    chk($sformatf("blk_last_%0d", k), {511'd0, blk_last[k]}, {511'd0, e.last});
                    if (blk_ready[k]) void'(exp_q[k].pop_front());
                end
            end
            if (!rst && done[k]) done_cnt[k]++;
        end
    end

    // Issue start; return edges from the sampling edge to blk_valid.
    task automatic do_start(input int k, input logic [15:0] addr, output int lat);
        @(posedge clk); #1;
        input_addr[k] = addr;
        start[k]      = 1'b1;
        @(posedge clk); #1;
        start[k]      = 1'b0;
        input_addr[k] = 16'hDEAD;
        lat = 0;
        while (!blk_valid[k] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_done(input int k);
        int t;
        t = 0;
        while (!done[k] && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        chk($sformatf("done_timeout_%0d", k), {511'd0, done[k]}, 512'd1);
        chk($sformatf("busy_with_done_%0d", k), {511'd0, busy[k]}, 512'd1);
        @(posedge clk); #1;
        chk($sformatf("done_one_cycle_%0d", k), {511'd0, done[k]}, 512'd0);
        chk($sformatf("busy_after_done_%0d", k), {511'd0, busy[k]}, 512'd0);
    endtask

    task automatic push_n40(input int k);
        push(k, 1'b0, seq_block(1));
        push(k, 1'b0, seq_block(17));
        push(k, 1'b1, {32'd33, 32'd34, 32'd35, 32'd36, 32'd37, 32'd38, 32'd39, 32'd40,
                       32'h8000_0000, 192'h0, 32'h0000_0500});
    endtask

    initial begin
        int lat;
        int t;
        int d0;
        logic [511:0] n13_blk;

        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            start[k]      = 1'b0;
            input_addr[k] = 16'h0000;
            blk_ready[k]  = 1'b0;
            done_cnt[k]   = 0;
        end
        n13_blk = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9,
                   32'd10, 32'd11, 32'd12, 32'd13, 32'h8000_0000, 32'h0, 32'h0000_01A0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_addr",  {496'd0, mem_addr[0]},  512'd0);
        chk("rst_blk_valid", {511'd0, blk_valid[0]}, 512'd0);
        chk("rst_blk_data",  blk_data[0],            512'd0);
        chk("rst_blk_last",  {511'd0, blk_last[0]},  512'd0);
        chk("rst_busy",      {511'd0, busy[0]},      512'd0);
        chk("rst_done",      {511'd0, done[0]},      512'd0);
        rst = 1'b0;

        // N=40, ready held high; stray starts during FETCH and VALID.
        blk_ready[0] = 1'b1;
        push_n40(0);
        do_start(0, 16'h0100, lat);
        chk("latency_n40", 512'(lat), 512'd17);
        start[0] = 1'b1; input_addr[0] = 16'h2000;
        t = 0;
        @(posedge clk); #1;
        t++;
        start[0] = 1'b0;
        while (!blk_valid[0] && t < 100) begin
            if (t == 5) begin
                start[0] = 1'b1;
            end else begin
                start[0] = 1'b0;
            end
            @(posedge clk); #1;
            t++;
        end
        chk("throughput_n40", 512'(t), 512'd18);
        wait_done(0);
        chk("n40_queue_empty", 512'(exp_q[0].size()), 512'd0);

        // N=13 single block; start held through the DONE cycle.
        blk_ready[1] = 1'b1;
        push(1, 1'b1, n13_blk);
        push(1, 1'b1, n13_blk);
        do_start(1, 16'h0100, lat);
        chk("latency_n13", 512'(lat), 512'd17);
        t = 0;
        while (!done[1] && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("n13_done_seen", {511'd0, done[1]}, 512'd1);
        start[1] = 1'b1; input_addr[1] = 16'h0100;
        @(posedge clk); #1;
        chk("start_in_done_ignored", {511'd0, busy[1]}, 512'd0);
        @(posedge clk); #1;
        start[1] = 1'b0;
        chk("start_after_done_taken", {511'd0, busy[1]}, 512'd1);
        wait_done(1);

        // N=14 with 5 cycles of backpressure on the first block.
        push(2, 1'b0, {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9,
                       32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'h8000_0000, 32'h0});
        push(2, 1'b1, {480'h0, 32'h0000_01C0});
        do_start(2, 16'h0100, lat);
        chk("latency_n14", 512'(lat), 512'd17);
        repeat (5) @(posedge clk);
        #1;
        chk("stall_valid_held", {511'd0, blk_valid[2]}, 512'd1);
        blk_ready[2] = 1'b1;
        @(posedge clk); #1;
        chk("handshake_first_high", {511'd0, blk_valid[2]}, 512'd0);
        wait_done(2);

        // N=16: padding marker starts the second block.
        blk_ready[3] = 1'b1;
        push(3, 1'b0, seq_block(1));
        push(3, 1'b1, {32'h8000_0000, 448'h0, 32'h0000_0200});
        do_start(3, 16'h0100, lat);
        wait_done(3);

        // Reset at c=7 of block1, then a fresh message.
        push(0, 1'b0, seq_block(1));
        do_start(0, 16'h0100, lat);
        @(posedge clk); #1;
        repeat (7) @(posedge clk);
        #1;
        d0 = done_cnt[0];
        rst = 1'b1;
        #1;
        chk("midrst_mem_addr",  {496'd0, mem_addr[0]},  512'd0);
        chk("midrst_blk_valid", {511'd0, blk_valid[0]}, 512'd0);
        chk("midrst_blk_data",  blk_data[0],            512'd0);
        chk("midrst_busy",      {511'd0, busy[0]},      512'd0);
        chk("midrst_done",      {511'd0, done[0]},      512'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_done", 512'(done_cnt[0]), 512'(d0));
        chk("midrst_queue", 512'(exp_q[0].size()), 512'd0);
        push_n40(0);
        do_start(0, 16'h0100, lat);
        chk("latency_after_rst", 512'(lat), 512'd17);
        wait_done(0);

        for (int k = 0; k < NI; k++) begin
            chk($sformatf("queue_empty_%0d", k), 512'(exp_q[k].size()), 512'd0);
        end
        chk("done_count_0", 512'(done_cnt[0]), 512'd2);
        chk("done_count_1", 512'(done_cnt[1]), 512'd2);
        chk("done_count_2", 512'(done_cnt[2]), 512'd1);
        chk("done_count_3", 512'(done_cnt[3]), 512'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
